pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Detects load-use hazards, taken branches/jumps resolved in EX, I-mem stalls and multi-cycle D-mem accesses.
//  Drives per-register enable/flush so the pipe freezes, bubbles or squashes exactly as required.
//  Sits beside the pipe_* register modules; owns all stall/flush decisions in the core.
// PARAMETERS
//  REG_W     3   register-index width
//  FLUSH_CYC 1   cycles IF/ID is squashed after a taken branch (legal 1..4; covers fetch latency)
//  CNT_W     16  perf-counter width (only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk           in  1      core clock
//  rst           in  1      synchronous, active-high reset
//  id_rs/id_rt   in  REG_W  source regs of the instruction in ID
//  id_rs_vld/id_rt_vld in 1 corresponding source actually read
//  ex_mem_read   in  1      instruction in EX (ID/EX output) is a load
//  ex_rd         in  REG_W  destination of that load
//  branch_taken  in  1      EX resolved a taken branch/jump this cycle
//  imem_stall    in  1      fetch not ready this cycle
//  dmem_req      in  1      MEM stage issuing a D-mem access (EX/MEM Mem_en)
//  dmem_stall    in  1      D-mem busy; dmem_done in 1: D-mem access completes this cycle
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1  register load enables
//  if_id_flush, id_ex_flush, mem_wb_bubble          out 1  load NOP/zero-control instead of d
//  state_o       out 2      current state (RUN=0, FLUSH=1, MEM_WAIT=2)
//  stall_cnt, flush_cnt out CNT_W  perf counters (PIPE_CTRL_PERF_EN only)
// BEHAVIOUR
//  - Registered: state, flush counter fcnt, saved state ret_flush, perf counters. All other outputs combinational.
//  - rst=1: next state RUN, fcnt=0, perf counters 0. While rst=1: all *_en=1, flush/bubble=0, state_o=0.
//  - load_use = ex_mem_read & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
//  - Default (no rule fires): all *_en=1, all flush/bubble=0.
//  - RUN. Priority order, first match wins:
//    1 dmem_req & dmem_stall & ~dmem_done: all *_en=0 except mem_wb_en=1, mem_wb_bubble=1; ->MEM_WAIT.
//    2 branch_taken: all *_en=1, if_id_flush=1, id_ex_flush=1; FLUSH_CYC>1 -> FLUSH with fcnt=FLUSH_CYC-1.
//    3 load_use: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble; stay RUN.
//    4 imem_stall: pc_en=0, if_id_flush=1; stay RUN.
//  - FLUSH: if_id_flush=1 each cycle; load_use and branch_taken are ignored (ID/EX holds a bubble).
//    fcnt decrements; at fcnt==1 -> RUN. Rule 1 preempts: freeze fcnt, set ret_flush=1, ->MEM_WAIT.
//  - MEM_WAIT: freeze as rule 1 until dmem_done.
//    dmem_done cycle: stalls released, outputs evaluated as the return state (RUN rules 2-4, or FLUSH).
//    Next state: FLUSH if ret_flush, else RUN/FLUSH per rule 2. Clear ret_flush.
//    dmem_done & dmem_stall in the same cycle: done wins.
//  - dmem_done outside MEM_WAIT with dmem_stall=0: single-cycle access, no stall.
//  - rst mid-MEM_WAIT/FLUSH: abandon sequence, RUN next cycle; no pending flush survives.
//  - Latency: hazard->enables same cycle (0-cycle combinational); state change visible next edge.
//  - Invariants: never pc_en=1 with if_id_en=0. Never a flush and a 0 enable on the same register.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//    stall_cnt +1 every cycle pc_en=0 (non-reset). flush_cnt +1 every cycle if_id_flush=1.
//    Both saturate at all-ones, reset to 0.
//  Undefined: counters and ports stall_cnt/flush_cnt absent; no other behaviour change.
// TESTING
//  1 reset: rst=1 2 cycles, release -> state_o=0, all *_en=1, flushes 0; perf counters 0.
//  2 load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_rs_vld=1 ->
//    pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle, then normal.
//  3 D-mem: dmem_req=1, dmem_stall=1 for 3 cycles, dmem_done on 4th ->
//    3 freeze cycles (mem_wb_bubble=1), all en=1 on cycle 4, state 0->2->0.
//  4 branch, FLUSH_CYC=3: branch_taken 1 cycle -> id_ex_flush 1 cycle,
//    if_id_flush 3 cycles, state 0->1->1->0; load_use during FLUSH ignored.
//  5 overlap: FLUSH_CYC=3, D-mem stall 2 cycles arriving in 2nd flush cycle ->
//    MEM_WAIT, then one remaining FLUSH cycle, then RUN.
//  6 reset mid-MEM_WAIT -> RUN next cycle. PERF_EN: stall_cnt matches count of pc_en=0 cycles;
//    force CNT_W=4, 20 stalls -> saturates at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core registers and PC.
// Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W     = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             imem_stall,
    input  logic             dmem_req,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
`else
    output logic [1:0]       state_o
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int FC_W = 3;

    state_t          state, state_nxt;
    logic [FC_W-1:0] fcnt, fcnt_nxt;
    logic            ret_flush, ret_flush_nxt;
    logic            load_use, freeze;
    logic            do_frz, do_run, do_fl;

    assign load_use = ex_mem_read &
                      ((id_rs_vld & (id_rs == ex_rd)) |
                       (id_rt_vld & (id_rt == ex_rd)));
    assign freeze   = dmem_req & dmem_stall & ~dmem_done;
    assign state_o  = rst ? 2'd0 : state;

    // State, squash counter and return-to-flush flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fcnt      <= '0;
            ret_flush <= 1'b0;
        end else begin
            state     <= state_nxt;
            fcnt      <= fcnt_nxt;
            ret_flush <= ret_flush_nxt;
        end
    end

    // Pick the active rule set, then derive enables and next state.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        ret_flush_nxt = ret_flush;
        do_frz        = 1'b0;
        do_run        = 1'b0;
        do_fl         = 1'b0;

        if (rst) begin
            state_nxt     = RUN;
            fcnt_nxt      = '0;
            ret_flush_nxt = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (freeze) begin
                        do_frz        = 1'b1;
                        state_nxt     = MEM_WAIT;
                        ret_flush_nxt = 1'b0;
                    end else begin
                        do_run = 1'b1;
                    end
                end
                FLUSH: begin
                    if (freeze) begin
                        do_frz        = 1'b1;
                        state_nxt     = MEM_WAIT;
                        ret_flush_nxt = 1'b1;
                    end else begin
                        do_fl = 1'b1;
                        if (fcnt <= FC_W'(1)) begin
                            state_nxt = RUN;
                            fcnt_nxt  = '0;
                        end else begin
                            fcnt_nxt = fcnt - 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_done) begin
                        do_frz = 1'b1;
                    end else begin
                        ret_flush_nxt = 1'b0;
                        if (ret_flush) begin
                            do_fl     = 1'b1;
                            state_nxt = FLUSH;
                        end else begin
                            do_run = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    fcnt_nxt  = '0;
                end
            endcase
        end

        if (do_frz) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (do_fl) begin
            if_id_flush = 1'b1;
        end else if (do_run) begin
            state_nxt = RUN;
            if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_CYC > 1) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FC_W'(FLUSH_CYC - 1);
                end
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (imem_stall) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating stall and squash cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
